// File: rtl/instr_issue.sv
// ---------------------------------------------------------------------------
// instr_issue
//   Fetch/decode/issue stage that feeds the 4-stage ALU pipeline. A program
//   store of packed 24-bit words is read combinationally at pc. The bundle
//   func/rd/rs1/rs2/addr is issued at most once per cycle with out_valid.
//   Bubbles are inserted on read-after-write hazards against the last
//   HAZ_WINDOW issued destinations. A func=15 word halts the stage.
//
//   Instruction word: func[23:20] rd[19:16] rs1[15:12] rs2[11:8] addr[7:0]
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle pulse, runs from pc 0 (IDLE or HALTED)
//   hold                 back-pressure, freezes every register in RUN
//   prog_we/waddr/wdata  program-store write (ignored in RUN)
//   rs1, rs2, rd, func,
//   addr, out_valid      issued bundle and its qualifier
//   busy, halted         state flags (RUN, HALTED)
//   illegal              sticky: a func 12..14 word was fetched
//   pc                   current fetch address (zero-extended to 8 bits)
//
// Handshake: out_valid marks a new instruction on the edge it rises or stays
// high without hold; while hold=1 the bundle and out_valid are frozen, so
// the consumer sees the same instruction until hold is released.
// ---------------------------------------------------------------------------
module instr_issue #(
    parameter int PROG_DEPTH = 256,
    parameter int HAZ_WINDOW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic        prog_we,
    input  logic [7:0]  prog_waddr,
    input  logic [23:0] prog_wdata,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        out_valid,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [7:0]  pc
);

    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;

    logic [23:0] mem [PROG_DEPTH];
    logic [23:0] word;

    logic [3:0] f_func, f_rd, f_rs1, f_rs2;
    logic [7:0] f_addr;
    logic       uses_a, uses_b, hazard;

    // History of issued destinations, entry 0 is the most recent issue.
    logic [HAZ_WINDOW-1:0]      hist_v, hist_v_d;
    logic [HAZ_WINDOW-1:0][3:0] hist_rd, hist_rd_d;

    logic [3:0] rs1_d, rs2_d, rd_d, func_d;
    logic [7:0] addr_d;
    logic       out_valid_d, illegal_d;
    logic       shift, shift_v;

    // Program store: no reset, written only while not running.
    always_ff @(posedge clk) begin
        if (prog_we && state_q != S_RUN) begin
            mem[prog_waddr[AW-1:0]] <= prog_wdata;
        end
    end

    assign word   = mem[pc_q];
    assign f_func = word[23:20];
    assign f_rd   = word[19:16];
    assign f_rs1  = word[15:12];
    assign f_rs2  = word[11:8];
    assign f_addr = word[7:0];

    always_comb begin
        uses_a = 1'b0;
        uses_b = 1'b0;
        case (f_func)
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
                uses_a = 1'b1;
                uses_b = 1'b1;
            end
            4'd3, 4'd8, 4'd10, 4'd11: uses_a = 1'b1;
            4'd4, 4'd9:               uses_b = 1'b1;
            default: ;
        endcase
    end

    // A matching entry at distance d drops out after HAZ_WINDOW-d+1 bubble
    // shifts, which gives the required stall length without a counter.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WINDOW; i++) begin
            if (hist_v[i] && ((uses_a && hist_rd[i] == f_rs1) ||
                              (uses_b && hist_rd[i] == f_rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rs1_d       = rs1;
        rs2_d       = rs2;
        rd_d        = rd;
        func_d      = func;
        addr_d      = addr;
        out_valid_d = out_valid;
        illegal_d   = illegal;
        hist_v_d    = hist_v;
        hist_rd_d   = hist_rd;
        shift       = 1'b0;
        shift_v     = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                out_valid_d = 1'b0;
                if (start) begin
                    state_d   = S_RUN;
                    pc_d      = '0;
                    illegal_d = 1'b0;
                    hist_v_d  = '0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    shift       = 1'b1;
                    out_valid_d = 1'b0;
                    if (f_func == 4'd15) begin
                        state_d = S_HALTED;
                    end else if (hazard) begin
                        pc_d = pc_q;
                    end else if (f_func >= 4'd12) begin
                        illegal_d = 1'b1;
                        pc_d      = pc_q + AW'(1);
                    end else begin
                        rs1_d       = f_rs1;
                        rs2_d       = f_rs2;
                        rd_d        = f_rd;
                        func_d      = f_func;
                        addr_d      = f_addr;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + AW'(1);
                        shift_v     = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (shift) begin
            for (int i = HAZ_WINDOW - 1; i > 0; i--) begin
                hist_v_d[i]  = hist_v[i-1];
                hist_rd_d[i] = hist_rd[i-1];
            end
            hist_v_d[0]  = shift_v;
            hist_rd_d[0] = f_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            func      <= '0;
            addr      <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            hist_v    <= '0;
            hist_rd   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rs1       <= rs1_d;
            rs2       <= rs2_d;
            rd        <= rd_d;
            func      <= func_d;
            addr      <= addr_d;
            out_valid <= out_valid_d;
            illegal   <= illegal_d;
            hist_v    <= hist_v_d;
            hist_rd   <= hist_rd_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign halted = (state_q == S_HALTED);
    assign pc     = 8'(pc_q);

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: a default instance (PROG_DEPTH=256) and a small
// instance (PROG_DEPTH=4) for pc wrap. Expected issued bundles are pushed to
// exp_q when a program is loaded and popped whenever out_valid is seen.
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, hold = 1'b0, prog_we = 1'b0;
    logic [7:0]  prog_waddr = '0;
    logic [23:0] prog_wdata = '0;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr, pc;
    logic        out_valid, busy, halted, illegal;

    logic        start_s = 1'b0, hold_s = 1'b0, prog_we_s = 1'b0;
    logic [7:0]  prog_waddr_s = '0;
    logic [23:0] prog_wdata_s = '0;
    logic [3:0]  rs1_s, rs2_s, rd_s, func_s;
    logic [7:0]  addr_s, pc_s;
    logic        out_valid_s, busy_s, halted_s, illegal_s;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_w;
    logic [23:0] got, got_s;

    assign got   = {func, rd, rs1, rs2, addr};
    assign got_s = {func_s, rd_s, rs1_s, rs2_s, addr_s};

    instr_issue u_dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .out_valid(out_valid), .busy(busy), .halted(halted),
        .illegal(illegal), .pc(pc)
    );

    instr_issue #(.PROG_DEPTH(4), .HAZ_WINDOW(2)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .hold(hold_s),
        .prog_we(prog_we_s), .prog_waddr(prog_waddr_s), .prog_wdata(prog_wdata_s),
        .rs1(rs1_s), .rs2(rs2_s), .rd(rd_s), .func(func_s), .addr(addr_s),
        .out_valid(out_valid_s), .busy(busy_s), .halted(halted_s),
        .illegal(illegal_s), .pc(pc_s)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] d,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [7:0] ad);
        return {f, d, a, b, ad};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [23:0] w);
        prog_we = 1'b1; prog_waddr = a; prog_wdata = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic load_s(input logic [7:0] a, input logic [23:0] w);
        prog_we_s = 1'b1; prog_waddr_s = a; prog_wdata_s = w;
        tick();
        prog_we_s = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        chk_cnt++;
        if (got !== 24'h0) $display("FAIL reset_bundle: got %h want 000000", got);
        else pass_cnt++;
        chk_cnt++;
        if ({out_valid, busy, halted, illegal} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {out_valid, busy, halted, illegal});
        else pass_cnt++;
        chk_cnt++;
        if (pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if ({busy, halted, out_valid} !== 3'b000)
            $display("FAIL idle_no_start: got %b want 000", {busy, halted, out_valid});
        else pass_cnt++;
    endtask

    task automatic test_independent();
        int n_iss = 0, first_k = 0, halt_k = 0;
        load(8'd0, mk(4'd0, 4'hA, 4'd3, 4'd5, 8'h7D));
        load(8'd1, mk(4'd1, 4'hB, 4'd4, 4'd6, 8'h7E));
        load(8'd2, mk(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
        exp_q.push_back(mk(4'd0, 4'hA, 4'd3, 4'd5, 8'h7D));
        exp_q.push_back(mk(4'd1, 4'hB, 4'd4, 4'd6, 8'h7E));
        pulse_start();
        chk_cnt++;
        if ({busy, out_valid} !== 2'b10)
            $display("FAIL ind_run_no_issue: got %b want 10", {busy, out_valid});
        else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (out_valid) begin
                n_iss++;
                if (first_k == 0) first_k = k;
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL ind_extra_issue: got %h want none", got);
                else begin
                    exp_w = exp_q.pop_front();
                    if (got !== exp_w) $display("FAIL ind_bundle: got %h want %h", got, exp_w);
                    else pass_cnt++;
                end
            end
            if (halted && halt_k == 0) halt_k = k;
        end
        chk_cnt++;
        if (n_iss !== 2) $display("FAIL ind_issue_count: got %0d want 2", n_iss);
        else pass_cnt++;
        chk_cnt++;
        if (first_k !== 1) $display("FAIL ind_latency: got %0d want 1", first_k);
        else pass_cnt++;
        chk_cnt++;
        if (halt_k !== 3) $display("FAIL ind_halt_cycle: got %0d want 3", halt_k);
        else pass_cnt++;
        chk_cnt++;
        if ({pc, rd, out_valid} !== {8'd2, 4'hB, 1'b0})
            $display("FAIL ind_halt_hold: got pc=%h rd=%h ov=%b want pc=02 rd=b ov=0", pc, rd, out_valid);
        else pass_cnt++;
    endtask

    // Also covers a program write landing on the same edge as start from HALTED.
    task automatic test_raw_hazard();
        logic       e_ov [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] e_pc [5] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
        load(8'd0, mk(4'd0, 4'hA, 4'd3, 4'd5, 8'h7D));
        exp_q.push_back(mk(4'd0, 4'hA, 4'd3, 4'd5, 8'h7D));
        exp_q.push_back(mk(4'd0, 4'hC, 4'hA, 4'd2, 8'h7E));
        prog_we = 1'b1; prog_waddr = 8'd1; prog_wdata = mk(4'd0, 4'hC, 4'hA, 4'd2, 8'h7E);
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_cnt++;
            if ({out_valid, pc} !== {e_ov[k], e_pc[k]})
                $display("FAIL raw_cycle%0d: got ov=%b pc=%h want ov=%b pc=%h", k + 1, out_valid, pc, e_ov[k], e_pc[k]);
            else pass_cnt++;
            if (out_valid) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL raw_extra_issue: got %h want none", got);
                else begin
                    exp_w = exp_q.pop_front();
                    if (got !== exp_w) $display("FAIL raw_bundle: got %h want %h", got, exp_w);
                    else pass_cnt++;
                end
            end
        end
        chk_cnt++;
        if ({halted, exp_q.size() == 0} !== 2'b11)
            $display("FAIL raw_end: got halted=%b left=%0d want halted=1 left=0", halted, exp_q.size());
        else pass_cnt++;
    endtask

    // func 3 ignores rs2 and func 4 ignores rs1, so neither may stall.
    task automatic test_operand_filter();
        logic e_ov [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        load(8'd0, mk(4'd0, 4'd4, 4'd1, 4'd2, 8'h10));
        load(8'd1, mk(4'd3, 4'd5, 4'd1, 4'd4, 8'h11));
        load(8'd2, mk(4'd4, 4'd6, 4'd5, 4'd0, 8'h12));
        load(8'd3, mk(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
        exp_q.push_back(mk(4'd0, 4'd4, 4'd1, 4'd2, 8'h10));
        exp_q.push_back(mk(4'd3, 4'd5, 4'd1, 4'd4, 8'h11));
        exp_q.push_back(mk(4'd4, 4'd6, 4'd5, 4'd0, 8'h12));
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_cnt++;
            if (out_valid !== e_ov[k])
                $display("FAIL filt_cycle%0d: got ov=%b want %b", k + 1, out_valid, e_ov[k]);
            else pass_cnt++;
            if (out_valid) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL filt_extra_issue: got %h want none", got);
                else begin
                    exp_w = exp_q.pop_front();
                    if (got !== exp_w) $display("FAIL filt_bundle: got %h want %h", got, exp_w);
                    else pass_cnt++;
                end
            end
        end
        chk_cnt++;
        if (halted !== 1'b1) $display("FAIL filt_halt: got %b want 1", halted);
        else pass_cnt++;
    endtask

    // Dependency at distance 2 stalls for HAZ_WINDOW-(2-1) = 1 cycle.
    task automatic test_distance2();
        logic       e_ov [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] e_pc [5] = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
        load(8'd0, mk(4'd0, 4'd7, 4'd1, 4'd1, 8'h20));
        load(8'd1, mk(4'd0, 4'd8, 4'd2, 4'd2, 8'h21));
        load(8'd2, mk(4'd0, 4'd9, 4'd7, 4'd3, 8'h22));
        load(8'd3, mk(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
        exp_q.push_back(mk(4'd0, 4'd7, 4'd1, 4'd1, 8'h20));
        exp_q.push_back(mk(4'd0, 4'd8, 4'd2, 4'd2, 8'h21));
        exp_q.push_back(mk(4'd0, 4'd9, 4'd7, 4'd3, 8'h22));
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_cnt++;
            if ({out_valid, pc} !== {e_ov[k], e_pc[k]})
                $display("FAIL dist2_cycle%0d: got ov=%b pc=%h want ov=%b pc=%h", k + 1, out_valid, pc, e_ov[k], e_pc[k]);
            else pass_cnt++;
            if (out_valid) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL dist2_extra_issue: got %h want none", got);
                else begin
                    exp_w = exp_q.pop_front();
                    if (got !== exp_w) $display("FAIL dist2_bundle: got %h want %h", got, exp_w);
                    else pass_cnt++;
                end
            end
        end
        chk_cnt++;
        if ({halted, exp_q.size() == 0} !== 2'b11)
            $display("FAIL dist2_end: got halted=%b left=%0d want 1/0", halted, exp_q.size());
        else pass_cnt++;
    endtask

    // Hold freezes everything; start and prog_we during RUN are ignored.
    task automatic test_hold();
        logic [23:0] snap;
        for (int i = 0; i < 4; i++) begin
            load(8'(i), mk(4'd0, 4'(i + 1), 4'hE, 4'hF, 8'(8'h30 + i)));
            exp_q.push_back(mk(4'd0, 4'(i + 1), 4'hE, 4'hF, 8'(8'h30 + i)));
        end
        load(8'd4, mk(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            if (k == 1) hold = 1'b1;
            if (k == 4) hold = 1'b0;
            if (k == 5) begin
                start = 1'b1; prog_we = 1'b1; prog_waddr = 8'd3;
                prog_wdata = mk(4'd0, 4'd9, 4'd9, 4'd9, 8'h99);
            end
            if (k == 6) begin
                start = 1'b0; prog_we = 1'b0;
            end
            tick();
            if (k >= 1 && k <= 3) begin
                chk_cnt++;
                if ({got, out_valid, pc} !== {snap, 1'b1, 8'd1})
                    $display("FAIL hold_cycle%0d: got %h ov=%b pc=%h want %h ov=1 pc=01", k, got, out_valid, pc, snap);
                else pass_cnt++;
            end else if (out_valid) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL hold_extra_issue: got %h want none", got);
                else begin
                    exp_w = exp_q.pop_front();
                    if (got !== exp_w) $display("FAIL hold_bundle: got %h want %h", got, exp_w);
                    else pass_cnt++;
                end
            end
            if (k == 0) snap = got;
        end
        chk_cnt++;
        if ({halted, pc, exp_q.size() == 0} !== {1'b1, 8'd4, 1'b1})
            $display("FAIL hold_end: got halted=%b pc=%h left=%0d want 1/04/0", halted, pc, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_illegal_clear();
        load(8'd0, mk(4'd12, 4'd1, 4'd2, 4'd3, 8'h40));
        load(8'd1, mk(4'd15, 4'd0, 4'd0, 4'd0, 8'h00));
        pulse_start();
        tick();
        chk_cnt++;
        if ({illegal, out_valid, pc} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL ill_set: got ill=%b ov=%b pc=%h want 1/0/01", illegal, out_valid, pc);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({halted, illegal} !== 2'b11)
            $display("FAIL ill_sticky_halted: got %b want 11", {halted, illegal});
        else pass_cnt++;
        pulse_start();
        chk_cnt++;
        if ({busy, illegal} !== 2'b10)
            $display("FAIL ill_cleared_by_start: got %b want 10", {busy, illegal});
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if ({halted, illegal} !== 2'b11)
            $display("FAIL ill_reset_again: got %b want 11", {halted, illegal});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic       e_ov [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] e_pc [6] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
        load_s(8'd0, mk(4'd12, 4'd0, 4'd0, 4'd0, 8'h00));
        load_s(8'd1, mk(4'd0, 4'd5, 4'd1, 4'd2, 8'h51));
        load_s(8'd2, mk(4'd0, 4'd6, 4'd1, 4'd2, 8'h52));
        load_s(8'd3, mk(4'd0, 4'd7, 4'd1, 4'd2, 8'h53));
        exp_q.push_back(mk(4'd0, 4'd5, 4'd1, 4'd2, 8'h51));
        exp_q.push_back(mk(4'd0, 4'd6, 4'd1, 4'd2, 8'h52));
        exp_q.push_back(mk(4'd0, 4'd7, 4'd1, 4'd2, 8'h53));
        exp_q.push_back(mk(4'd0, 4'd5, 4'd1, 4'd2, 8'h51));
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_cnt++;
            if ({out_valid_s, pc_s, illegal_s} !== {e_ov[k], e_pc[k], 1'b1})
                $display("FAIL wrap_cycle%0d: got ov=%b pc=%h ill=%b want ov=%b pc=%h ill=1",
                         k + 1, out_valid_s, pc_s, illegal_s, e_ov[k], e_pc[k]);
            else pass_cnt++;
            if (out_valid_s) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL wrap_extra_issue: got %h want none", got_s);
                else begin
                    exp_w = exp_q.pop_front();
                    if (got_s !== exp_w) $display("FAIL wrap_bundle: got %h want %h", got_s, exp_w);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 8; i++) load(8'(i), mk(4'd0, 4'(i + 1), 4'hE, 4'hF, 8'(8'h60 + i)));
        pulse_start();
        tick();
        tick();
        chk_cnt++;
        if ({out_valid, busy} !== 2'b11) $display("FAIL rst_pre_running: got %b want 11", {out_valid, busy});
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({got, out_valid, busy, halted, illegal, pc} !== '0)
            $display("FAIL rst_async_main: got %h ov=%b busy=%b halt=%b ill=%b pc=%h want all 0",
                     got, out_valid, busy, halted, illegal, pc);
        else pass_cnt++;
        chk_cnt++;
        if ({got_s, out_valid_s, busy_s, illegal_s, pc_s} !== '0)
            $display("FAIL rst_async_small: got %h ov=%b busy=%b ill=%b pc=%h want all 0",
                     got_s, out_valid_s, busy_s, illegal_s, pc_s);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++;
            if ({out_valid, busy, pc} !== 10'd0)
                $display("FAIL rst_no_issue%0d: got ov=%b busy=%b pc=%h want 0/0/00", k, out_valid, busy, pc);
            else pass_cnt++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_independent();
        test_raw_hazard();
        test_operand_filter();
        test_distance2();
        test_hold();
        test_illegal_clear();
        test_wrap();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
